// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_forward_unit_if : ID-stage hazard/forwarding bus (master=pipeline, slave=unit)
// Rev 1.0
// ============================================================================
interface hazard_forward_unit_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_reg_write;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic        freeze;
  logic        flush;
  logic [3:0]  redirection_ctrl;
  logic        stall;
  logic        ex_valid;
  logic [31:0] stall_count;
  // WB slot {valid, reg_write, dest, is_load}, exported for observation only
  logic [7:0]  wb_slot;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
           id_rd, id_is_load, freeze, flush,
    input  redirection_ctrl, stall, ex_valid, stall_count, wb_slot
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
           id_rd, id_is_load, freeze, flush,
    output redirection_ctrl, stall, ex_valid, stall_count, wb_slot
  );
endinterface
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// hazard_forward_unit : EX/MEM/WB slot tracker with operand forwarding and
// load-use stall. Optional stall counter enabled by macro HAZARD_STAT_EN.
// Rev 1.0
// ============================================================================
module hazard_forward_unit (
  input  wire logic             clk,
  input  wire logic             rst_n,
  hazard_forward_unit_if.slave  bus
);

  logic       ex_valid_q, ex_rw_q, ex_load_q;
  logic [4:0] ex_dest_q;
  logic       mem_valid_q, mem_rw_q, mem_load_q;
  logic [4:0] mem_dest_q;
  logic       wb_valid_q, wb_rw_q, wb_load_q;
  logic [4:0] wb_dest_q;
  logic [3:0] ctrl_q, ctrl_d;

  logic w_ex_wr, w_mem_wr;
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_stall, w_accept;

  // WB is deliberately excluded: the register file resolves that case itself
  always_comb begin
    w_ex_wr  = ex_valid_q & ex_rw_q & (ex_dest_q != 5'd0);
    w_mem_wr = mem_valid_q & mem_rw_q & (mem_dest_q != 5'd0);
    w_ex_rs  = w_ex_wr  & bus.id_uses_rs & (ex_dest_q  == bus.id_rs);
    w_ex_rt  = w_ex_wr  & bus.id_uses_rt & (ex_dest_q  == bus.id_rt);
    w_mem_rs = w_mem_wr & bus.id_uses_rs & (mem_dest_q == bus.id_rs);
    w_mem_rt = w_mem_wr & bus.id_uses_rt & (mem_dest_q == bus.id_rt);
    w_stall  = bus.id_valid & ~bus.flush & ex_load_q & (w_ex_rs | w_ex_rt);
    w_accept = bus.id_valid & ~bus.flush & ~w_stall;
    ctrl_d   = 4'b0000;
    if (w_accept) begin
      ctrl_d = {w_mem_rt & ~w_ex_rt, w_ex_rt, w_mem_rs & ~w_ex_rs, w_ex_rs};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_dest_q   <= 5'd0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_dest_q  <= 5'd0;
      mem_load_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_load_q   <= 1'b0;
      ctrl_q      <= 4'b0000;
    end else if (!bus.freeze) begin
      wb_valid_q  <= mem_valid_q;
      wb_rw_q     <= mem_rw_q;
      wb_dest_q   <= mem_dest_q;
      wb_load_q   <= mem_load_q;
      mem_valid_q <= ex_valid_q;
      mem_rw_q    <= ex_rw_q;
      mem_dest_q  <= ex_dest_q;
      mem_load_q  <= ex_load_q;
      // Stall, flush and idle ID all collapse to an all-zero bubble in EX
      ex_valid_q  <= w_accept;
      ex_rw_q     <= w_accept & bus.id_reg_write;
      ex_dest_q   <= w_accept ? bus.id_rd : 5'd0;
      ex_load_q   <= w_accept & bus.id_is_load;
      ctrl_q      <= ctrl_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 32'd0;
    end else if (w_stall && !bus.freeze) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = 32'd0;
`endif

  assign bus.redirection_ctrl = ctrl_q;
  assign bus.stall            = w_stall;
  assign bus.ex_valid         = ex_valid_q;
  assign bus.wb_slot          = {wb_valid_q, wb_rw_q, wb_dest_q, wb_load_q};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_forward_unit : random + directed scoreboard bench for hazard_forward_unit
// Rev 1.0
// ============================================================================
module tb_hazard_forward_unit;

  logic clk;
  logic rst_n;
  hazard_forward_unit_if bus ();

  hazard_forward_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       rw;
    bit [4:0] d;
    bit       ld;
  } slot_t;

  typedef struct {
    bit        stall;
    bit [3:0]  ctrl;
    bit        exv;
    bit [31:0] cnt;
    bit [7:0]  wb;
  } exp_t;

  // Reference model: index 0 = EX (newest), 1 = MEM, 2 = WB
  slot_t     m_pipe[3];
  bit [3:0]  m_ctrl;
  bit [31:0] m_cnt;
  exp_t      sb_q[$];

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{0, 0, 0, 0};
    m_ctrl = 4'b0;
    m_cnt  = 32'd0;
  endfunction

  // Which in-flight stage (0 = EX, 1 = MEM) produces the newest value of r; -1 none
  function automatic int youngest_writer(input bit [4:0] r);
    if (r == 5'd0) return -1;
    for (int i = 0; i < 2; i++)
      if (m_pipe[i].v && m_pipe[i].rw && m_pipe[i].d == r) return i;
    return -1;
  endfunction

  task automatic issue(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                       input bit urs, input bit urt, input bit rw,
                       input bit [4:0] rd, input bit ld,
                       input bit frz, input bit fl);
    exp_t e;
    int   wa, wb;
    bit   stl;
    @(negedge clk);
    bus.id_valid = v;      bus.id_rs = rs;       bus.id_rt = rt;
    bus.id_uses_rs = urs;  bus.id_uses_rt = urt; bus.id_reg_write = rw;
    bus.id_rd = rd;        bus.id_is_load = ld;  bus.freeze = frz;
    bus.flush = fl;
    #1;
    wa  = urs ? youngest_writer(rs) : -1;
    wb  = urt ? youngest_writer(rt) : -1;
    stl = v && !fl && m_pipe[0].ld && (wa == 0 || wb == 0);
    e.stall = stl;
    if (!frz) begin
      if (stl) m_cnt = m_cnt + 1;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      if (v && !fl && !stl) begin
        m_pipe[0] = '{1'b1, rw, rd, ld};
        m_ctrl = 4'b0;
        if (wa == 0) m_ctrl[0] = 1'b1;
        if (wa == 1) m_ctrl[1] = 1'b1;
        if (wb == 0) m_ctrl[2] = 1'b1;
        if (wb == 1) m_ctrl[3] = 1'b1;
      end else begin
        m_pipe[0] = '{0, 0, 0, 0};
        m_ctrl = 4'b0;
      end
    end
    e.ctrl = m_ctrl;
    e.exv  = m_pipe[0].v;
`ifdef HAZARD_STAT_EN
    e.cnt  = m_cnt;
`else
    e.cnt  = 32'd0;
`endif
    e.wb   = {m_pipe[2].v, m_pipe[2].rw, m_pipe[2].d, m_pipe[2].ld};
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0;
    bus.id_uses_rt = 0; bus.id_reg_write = 0; bus.id_rd = 0; bus.id_is_load = 0;
    bus.freeze = 0; bus.flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pre-edge combinational stall, then post-edge registered state
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("stall", 32'(bus.stall), 32'(e.stall));
        @(posedge clk);
        #1;
        if (!rst_n) begin
          check("rst_ctrl", 32'(bus.redirection_ctrl), 32'd0);
          check("rst_exv", 32'(bus.ex_valid), 32'd0);
          check("rst_cnt", bus.stall_count, 32'd0);
        end else begin
          check("ctrl", 32'(bus.redirection_ctrl), 32'(e.ctrl));
          check("ex_valid", 32'(bus.ex_valid), 32'(e.exv));
          check("stall_count", bus.stall_count, e.cnt);
          check("wb_slot", 32'(bus.wb_slot), 32'(e.wb));
        end
      end
    end
  end

  bit [31:0] exp_one;

  initial begin
    bit v, urs, urt, rw, ld, frz, fl, hold;
    bit [4:0] rs, rt, rd;
    n_tests = 0;
    n_fail  = 0;
`ifdef HAZARD_STAT_EN
    exp_one = 32'd1;
`else
    exp_one = 32'd0;
`endif
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("reset_ctrl", 32'(bus.redirection_ctrl), 32'd0);
    check("reset_exv", 32'(bus.ex_valid), 32'd0);
    check("reset_stall", 32'(bus.stall), 32'd0);
    do_reset();

    // Back-to-back ALU forward on rs
    issue(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    issue(1, 8, 9, 1, 1, 1, 10, 0, 0, 0);
    check("b2b_stall", 32'(bus.stall), 32'd0);
    after_edge();
    check("b2b_ctrl", 32'(bus.redirection_ctrl), 32'h1);

    // Both EX and MEM write $8: ALU wins on both operands
    do_reset();
    issue(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    issue(1, 8, 8, 1, 1, 1, 3, 0, 0, 0);
    after_edge();
    check("dbl_ctrl", 32'(bus.redirection_ctrl), 32'h5);

    // Load-use on rt
    do_reset();
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    issue(1, 1, 5, 0, 1, 1, 6, 0, 0, 0);
    check("lu_stall", 32'(bus.stall), 32'd1);
    after_edge();
    check("lu_bubble", 32'(bus.ex_valid), 32'd0);
    issue(1, 1, 5, 0, 1, 1, 6, 0, 0, 0);
    check("lu_stall_end", 32'(bus.stall), 32'd0);
    after_edge();
    check("lu_exv", 32'(bus.ex_valid), 32'd1);
    check("lu_ctrl", 32'(bus.redirection_ctrl), 32'h8);
    check("lu_cnt", bus.stall_count, exp_one);

    // $0 never forwards
    do_reset();
    issue(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    issue(1, 0, 1, 1, 0, 1, 4, 0, 0, 0);
    after_edge();
    check("r0_ctrl", 32'(bus.redirection_ctrl), 32'h0);

    // Flush beats load-use; freeze beats everything
    do_reset();
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    issue(1, 0, 5, 0, 1, 1, 6, 0, 0, 1);
    check("fl_stall", 32'(bus.stall), 32'd0);
    after_edge();
    check("fl_exv", 32'(bus.ex_valid), 32'd0);
    do_reset();
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    issue(1, 0, 5, 0, 1, 1, 6, 0, 1, 0);
    after_edge();
    check("frz_exv", 32'(bus.ex_valid), 32'd1);
    check("frz_cnt", bus.stall_count, 32'd0);

    // Asynchronous reset between edges while stalling
    do_reset();
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    issue(1, 0, 5, 0, 1, 1, 6, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'(bus.redirection_ctrl), 32'd0);
    check("arst_exv", 32'(bus.ex_valid), 32'd0);
    check("arst_stall", 32'(bus.stall), 32'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; a stalled instruction is re-presented until consumed
    hold = 0;
    v = 0; rs = 0; rt = 0; urs = 0; urt = 0; rw = 0; rd = 0; ld = 0;
    for (int n = 0; n < 500; n++) begin
      if (!hold) begin
        v   = ($urandom_range(0, 99) < 85);
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        urs = ($urandom_range(0, 99) < 80);
        urt = ($urandom_range(0, 99) < 60);
        rw  = ($urandom_range(0, 99) < 80);
        rd  = 5'($urandom_range(0, 3));
        ld  = ($urandom_range(0, 99) < 35);
      end
      frz = ($urandom_range(0, 99) < 10);
      fl  = ($urandom_range(0, 99) < 8);
      issue(v, rs, rt, urs, urt, rw, rd, ld, frz, fl);
      hold = bus.stall;
    end

    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
